// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl
//   Sequencer for the LED pattern datapath. A prescaler divides the clock
//   down to a step rate that i_rate selects. Each step, or each i_step pulse
//   while paused, advances a small pattern state machine that drives the LED
//   bank: rotate left, rotate right, ping-pong, or flash.
//
// Parameters
//   NB_LEDS   LED bank width (>=2)
//   NB_COUNT  prescaler counter width
//   RATE0..3  tick period in clocks for i_rate = 0..3 (each >=2)
//
// Ports
//   i_clk   in   1        system clock
//   i_rst   in   1        asynchronous active-low reset
//   i_en    in   1        1 = run (prescaler counts), 0 = pause (counter holds)
//   i_rate  in   2        rate select -> RATE0..RATE3
//   i_mode  in   2        00 rot-left, 01 rot-right, 10 ping-pong, 11 flash
//   i_step  in   1        single-cycle pulse; advances one step while paused
//   o_led   out  NB_LEDS  LED pattern (registered)
//   o_tick  out  1        high in the cycle o_led first shows a new value
//   o_dir   out  1        0 = moving toward MSB, 1 = moving toward LSB
module led_seq_ctrl #(
  parameter int          NB_LEDS  = 4,
  parameter int          NB_COUNT = 32,
  parameter int unsigned RATE0    = 50000000,
  parameter int unsigned RATE1    = 25000000,
  parameter int unsigned RATE2    = 10000000,
  parameter int unsigned RATE3    = 5000000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [1:0]         i_rate,
  input  logic [1:0]         i_mode,
  input  logic               i_step,
  output logic [NB_LEDS-1:0] o_led,
  output logic               o_tick,
  output logic               o_dir
);

  localparam logic [1:0] ST_SHIFT_L = 2'd0;
  localparam logic [1:0] ST_SHIFT_R = 2'd1;
  localparam logic [1:0] ST_FLASH   = 2'd2;

  localparam logic [1:0] MODE_ROT_L = 2'b00;
  localparam logic [1:0] MODE_ROT_R = 2'b01;
  localparam logic [1:0] MODE_PING  = 2'b10;
  localparam logic [1:0] MODE_FLASH = 2'b11;

  localparam logic [NB_LEDS-1:0]  LED_SEED = NB_LEDS'(1);
  localparam logic [NB_LEDS-1:0]  LED_ALL  = '1;
  localparam logic [NB_COUNT-1:0] CNT_ONE  = NB_COUNT'(1);

  function automatic logic [NB_LEDS-1:0] rot_l(input logic [NB_LEDS-1:0] v);
    return {v[NB_LEDS-2:0], v[NB_LEDS-1]};
  endfunction

  function automatic logic [NB_LEDS-1:0] rot_r(input logic [NB_LEDS-1:0] v);
    return {v[0], v[NB_LEDS-1:1]};
  endfunction

  logic [NB_COUNT-1:0] cnt;
  logic [NB_COUNT-1:0] limit;
  logic [NB_COUNT-1:0] limit_m1;
  logic                tick;
  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [NB_LEDS-1:0]  led_nxt;
  logic                led_one_hot;

  // Prescaler: the rate select feeds the compare directly, so lowering the
  // period below the current count fires a tick on the very next edge.
  always_comb begin
    case (i_rate)
      2'd0:    limit = NB_COUNT'(RATE0);
      2'd1:    limit = NB_COUNT'(RATE1);
      2'd2:    limit = NB_COUNT'(RATE2);
      default: limit = NB_COUNT'(RATE3);
    endcase
  end

  assign limit_m1 = limit - CNT_ONE;
  // While paused only the step button advances; while running it is ignored.
  assign tick     = i_en ? (cnt >= limit_m1) : i_step;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (i_en) begin
      cnt <= (cnt >= limit_m1) ? '0 : cnt + CNT_ONE;
    end
  end

  // Pattern next-state; only committed on a tick.
  assign led_one_hot = (o_led != '0) && ((o_led & (o_led - LED_SEED)) == '0);

  always_comb begin
    state_nxt = state;
    led_nxt   = o_led;
    if ((i_mode != MODE_FLASH) && !led_one_hot) begin
      // Shift modes need exactly one lit LED; re-seed instead of shifting.
      state_nxt = ST_SHIFT_L;
      led_nxt   = LED_SEED;
    end else begin
      case (state)
        ST_SHIFT_L: begin
          case (i_mode)
            MODE_ROT_L: led_nxt = rot_l(o_led);
            MODE_ROT_R: begin
              state_nxt = ST_SHIFT_R;
              led_nxt   = rot_r(o_led);
            end
            MODE_PING: begin
              if (o_led[NB_LEDS-1]) begin
                state_nxt = ST_SHIFT_R;
                led_nxt   = o_led >> 1;
              end else begin
                led_nxt = o_led << 1;
              end
            end
            default: begin
              state_nxt = ST_FLASH;
              led_nxt   = LED_ALL;
            end
          endcase
        end
        ST_SHIFT_R: begin
          case (i_mode)
            MODE_ROT_R: led_nxt = rot_r(o_led);
            MODE_ROT_L: begin
              state_nxt = ST_SHIFT_L;
              led_nxt   = rot_l(o_led);
            end
            MODE_PING: begin
              if (o_led[0]) begin
                state_nxt = ST_SHIFT_L;
                led_nxt   = o_led << 1;
              end else begin
                led_nxt = o_led >> 1;
              end
            end
            default: begin
              state_nxt = ST_FLASH;
              led_nxt   = LED_ALL;
            end
          endcase
        end
        ST_FLASH: begin
          if (i_mode == MODE_FLASH) begin
            // Toggle between all-on and all-off; anything else recovers to all-on.
            led_nxt = ((o_led == LED_ALL) || (o_led == '0)) ? ~o_led : LED_ALL;
          end else begin
            state_nxt = ST_SHIFT_L;
          end
        end
        default: begin
          state_nxt = ST_SHIFT_L;
          led_nxt   = LED_SEED;
        end
      endcase
    end
  end

  // Output registers: o_tick is the registered tick, aligned with the new o_led.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state  <= ST_SHIFT_L;
      o_led  <= LED_SEED;
      o_dir  <= 1'b0;
      o_tick <= 1'b0;
    end else begin
      o_tick <= tick;
      if (tick) begin
        state <= state_nxt;
        o_led <= led_nxt;
        o_dir <= (state_nxt == ST_SHIFT_R);
      end
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Testbench for led_seq_ctrl (NB_LEDS=4, RATE0..3 = 8,6,4,2).
// A behavioural model tracks the expected LED pattern per cycle; directed
// sequences add literal expectations for periods and pattern values.
module tb_led_seq_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       step  = 1'b0;
  logic [1:0] rate  = 2'd0;
  logic [1:0] mode  = 2'd0;
  logic [3:0] led;
  logic       tick;
  logic       dir;

  int errors = 0;
  int checks = 0;
  int tcount = 0;

  // Model state
  int rates[4] = '{8, 6, 4, 2};
  int m_cnt    = 0;
  int m_led    = 1;
  bit m_dir    = 1'b0;
  bit m_flash  = 1'b0;
  bit m_tick   = 1'b0;
  bit m_t      = 1'b0;

  led_seq_ctrl #(
    .NB_LEDS (4),
    .NB_COUNT(8),
    .RATE0   (8),
    .RATE1   (6),
    .RATE2   (4),
    .RATE3   (2)
  ) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .i_en  (en),
    .i_rate(rate),
    .i_mode(mode),
    .i_step(step),
    .o_led (led),
    .o_tick(tick),
    .o_dir (dir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One pattern step from the behavioural rules: m_dir tells which way the
  // single lit LED travels, m_flash whether we are in the flashing pattern.
  task automatic advance(input int md);
    if (md != 3 && $countones(m_led) != 1) begin
      m_led = 1; m_dir = 1'b0; m_flash = 1'b0;
    end else if (md == 3) begin
      m_led   = (m_flash && (m_led == 0 || m_led == 15)) ? (~m_led & 15) : 15;
      m_flash = 1'b1;
      m_dir   = 1'b0;
    end else if (m_flash) begin
      m_flash = 1'b0; m_dir = 1'b0;
    end else if (md == 0) begin
      m_dir = 1'b0; m_led = ((m_led << 1) | (m_led >> 3)) & 15;
    end else if (md == 1) begin
      m_dir = 1'b1; m_led = ((m_led >> 1) | (m_led << 3)) & 15;
    end else if (!m_dir) begin
      if (m_led == 8) begin m_dir = 1'b1; m_led = 4; end
      else m_led = m_led << 1;
    end else begin
      if (m_led == 1) begin m_dir = 1'b0; m_led = 2; end
      else m_led = m_led >> 1;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_cnt = 0; m_led = 1; m_dir = 1'b0; m_flash = 1'b0; m_tick = 1'b0;
    end else begin
      if (en) begin
        if (m_cnt >= rates[rate] - 1) begin m_cnt = 0; m_t = 1'b1; end
        else begin m_cnt++; m_t = 1'b0; end
      end else begin
        m_t = step;
      end
      m_tick = m_t;
      if (m_t) advance(int'(mode));
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (tick === 1'b1) tcount++;
    chk("cyc_led",  int'(led),  m_led);
    chk("cyc_tick", int'(tick), int'(m_tick));
    chk("cyc_dir",  int'(dir),  int'(m_dir));
  end

  task automatic wait_tick(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < 40);
    if (tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no tick within %0d cycles", name, n);
    end
  endtask

  task automatic step_chk(input string name, input int period, input int exp_led, input int exp_dir);
    int n;
    wait_tick(name, n);
    chk({name, "_period"}, n, period);
    chk({name, "_led"}, int'(led), exp_led);
    chk({name, "_dir"}, int'(dir), exp_dir);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int exp4[3] = '{4'b0010, 4'b0001, 4'b1000};

    repeat (2) @(negedge clk);
    chk("rst_led",  int'(led),  1);
    chk("rst_tick", int'(tick), 0);
    chk("rst_dir",  int'(dir),  0);

    // T1: rotate left at the fastest rate
    rst_n = 1'b1; en = 1'b1; rate = 2'd3; mode = 2'b00;
    step_chk("t1a", 2, 4'b0010, 0);
    step_chk("t1b", 2, 4'b0100, 0);
    step_chk("t1c", 2, 4'b1000, 0);
    step_chk("t1d", 2, 4'b0001, 0);

    // T2: ping-pong, period 4
    mode = 2'b10; rate = 2'd2;
    step_chk("t2a", 4, 4'b0010, 0);
    step_chk("t2b", 4, 4'b0100, 0);
    step_chk("t2c", 4, 4'b1000, 0);
    step_chk("t2d", 4, 4'b0100, 1);
    step_chk("t2e", 4, 4'b0010, 1);
    step_chk("t2f", 4, 4'b0001, 1);
    step_chk("t2g", 4, 4'b0010, 0);

    // T3: flash, then rotate right recovers through the seed
    mode = 2'b11;
    step_chk("t3a", 4, 4'b1111, 0);
    step_chk("t3b", 4, 4'b0000, 0);
    step_chk("t3c", 4, 4'b1111, 0);
    mode = 2'b01;
    step_chk("t3d", 4, 4'b0001, 0);
    step_chk("t3e", 4, 4'b1000, 1);
    step_chk("t3f", 4, 4'b0100, 1);

    // T4: paused single-stepping
    en = 1'b0;
    #1 t0 = tcount;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      @(negedge clk);
      chk("t4_step_tick", int'(tick), 1);
      chk("t4_step_led",  int'(led),  exp4[i]);
      step = 1'b0;
      repeat (4) begin
        @(negedge clk);
        chk("t4_idle_tick", int'(tick), 0);
      end
    end
    #1 chk("t4_tick_count", tcount - t0, 3);

    // T5: step ignored while running; rate change mid-count
    en = 1'b1; rate = 2'd0; step = 1'b1;
    @(negedge clk);
    chk("t5_step_en_tick", int'(tick), 0);
    step = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_hold_led", int'(led), 4'b1000);
    rate = 2'd2;
    @(negedge clk);
    chk("t5_fast_tick", int'(tick), 1);
    chk("t5_fast_led",  int'(led),  4'b0100);
    step_chk("t5a", 4, 4'b0010, 1);
    step_chk("t5b", 4, 4'b0001, 1);
    step_chk("t5c", 4, 4'b1000, 1);
    step_chk("t5d", 4, 4'b0100, 1);

    // T6: asynchronous reset mid-pattern, counter nonzero
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_led",  int'(led),  1);
    chk("t6_rst_tick", int'(tick), 0);
    chk("t6_rst_dir",  int'(dir),  0);
    @(negedge clk);
    rst_n = 1'b1;
    step_chk("t6_resume", 4, 4'b1000, 1);

    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
